scope_window_gen: RTL and testbench

- Upstream feeder of the 3x3 convolver.
- Accepts a raster-order 8-bit pixel stream with a valid/ready handshake and buffers two previous image lines.
- Emits every fully-interior 3x3 window as a packed 72-bit scope word, held until the convolver accepts it.
- No padding: an IMG_W x IMG_H frame yields (IMG_W-2)*(IMG_H-2) windows.

---
 rtl/conv_pkg.sv | 25 ++
 rtl/scope_window_gen_if.sv | 36 +++
 rtl/line_buffer.sv | 36 +++
 rtl/scope_window_gen.sv | 176 +++++++++++++++++
 tb/tb_scope_window_gen.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Definitions shared by the scope window generator and the 3x3 convolver.
package conv_pkg;

  localparam int unsigned PIX_W    = 8;
  localparam int unsigned WIN_TAPS = 9;
  localparam int unsigned WIN_W    = PIX_W * WIN_TAPS;
  localparam int unsigned COORD_W  = 10;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } win_state_t;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [WIN_W-1:0] scope_t;

  // Window taps; tap k = row*3 + col, row 0 is the oldest line, col 0 the leftmost.
  typedef pix_t [WIN_TAPS-1:0] win_taps_t;

  // Bit offset of a window element inside a scope word.
  function automatic int unsigned scope_off(input int unsigned row, input int unsigned col);
    return (row * 3 + col) * PIX_W;
  endfunction

endpackage

// File: rtl/scope_window_gen_if.sv
// Pixel-in / scope-out handshake bundle between the pixel source, the window
// generator and the convolver. Build option WIN_COORD_EN adds win_x/win_y.
interface scope_window_gen_if;
  import conv_pkg::*;

  pix_t   in_pix;
  logic   in_sof;
  logic   in_valid;
  logic   in_ready;
  scope_t scope;
  logic   scope_valid;
  logic   scope_ready;
  logic   frame_done;
  logic   frame_err;
`ifdef WIN_COORD_EN
  logic [COORD_W-1:0] win_x;
  logic [COORD_W-1:0] win_y;
`endif

  modport master (
    output in_pix, in_sof, in_valid, scope_ready,
    input  in_ready, scope, scope_valid, frame_done, frame_err
`ifdef WIN_COORD_EN
    , win_x, win_y
`endif
  );

  modport slave (
    input  in_pix, in_sof, in_valid, scope_ready,
    output in_ready, scope, scope_valid, frame_done, frame_err
`ifdef WIN_COORD_EN
    , win_x, win_y
`endif
  );

endinterface

// File: rtl/line_buffer.sv
// One image line of delay: dout_c is the pixel written DEPTH shift-enables ago.
module line_buffer
  import conv_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  pix_t din,
  output pix_t dout_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pix_t           mem [DEPTH];
  logic [AW-1:0]  ptr_q;

  // Circular pointer: the slot about to be overwritten holds the oldest pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (en) begin
      ptr_q <= (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr_q] <= din;
    end
  end

  assign dout_c = mem[ptr_q];

endmodule

// File: rtl/scope_window_gen.sv
// Raster pixel stream to fully-interior 3x3 scope words for the convolver.
// Build option WIN_COORD_EN adds registered window-centre coordinates.
module scope_window_gen
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W = 32,
  parameter int unsigned IMG_H = 32
) (
  input  logic              clk,
  input  logic              rst,
  scope_window_gen_if.slave sif
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);

  win_state_t       state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  win_taps_t        win_q, win_d;
  scope_t           scope_q, scope_d;
  logic             scope_valid_q, scope_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_err_q, frame_err_d;

  logic             in_ready_c;
  logic             accept_c;
  logic             resync_c;
  logic             last_col_c;
  logic             last_row_c;
  logic             emit_c;
  pix_t             buf0_c;
  pix_t             buf1_c;

  // Single output slot; a window may be replaced in the cycle it is taken.
  assign in_ready_c = !scope_valid_q || sif.scope_ready;
  assign accept_c   = sif.in_valid && in_ready_c;

  // buf1 delivers the pixel one line up, buf0 the pixel two lines up.
  line_buffer #(.DEPTH(IMG_W)) u_buf1 (
    .clk    (clk),
    .rst    (rst),
    .en     (accept_c),
    .din    (sif.in_pix),
    .dout_c (buf1_c)
  );

  line_buffer #(.DEPTH(IMG_W)) u_buf0 (
    .clk    (clk),
    .rst    (rst),
    .en     (accept_c),
    .din    (buf1_c),
    .dout_c (buf0_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FILL;
      col_q         <= '0;
      row_q         <= '0;
      win_q         <= '0;
      scope_q       <= '0;
      scope_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      win_q         <= win_d;
      scope_q       <= scope_d;
      scope_valid_q <= scope_valid_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
    end
  end

  // Raster position tracking, window shift and output slot control.
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    win_d         = win_q;
    scope_d       = scope_q;
    scope_valid_d = scope_valid_q;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;
    emit_c        = 1'b0;
    resync_c      = sif.in_sof && ((col_q != '0) || (row_q != '0));
    last_col_c    = (col_q == COL_W'(IMG_W - 1));
    last_row_c    = (row_q == ROW_W'(IMG_H - 1));

    if (scope_valid_q && sif.scope_ready) begin
      scope_valid_d = 1'b0;
    end

    if (accept_c) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = buf0_c;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = buf1_c;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = sif.in_pix;

      if (resync_c) begin
        // Misplaced start-of-frame: this pixel becomes (0,0) of a fresh frame.
        win_d       = '0;
        win_d[8]    = sif.in_pix;
        frame_err_d = 1'b1;
        col_d       = COL_W'(1);
        row_d       = '0;
        state_d     = FILL;
      end else begin
        emit_c = (state_q == STREAM) && (col_q >= COL_W'(2));
        if (last_col_c) begin
          col_d = '0;
          if (last_row_c) begin
            row_d        = '0;
            state_d      = FILL;
            frame_done_d = 1'b1;
          end else begin
            row_d = row_q + ROW_W'(1);
            if (row_q >= ROW_W'(1)) begin
              state_d = STREAM;
            end
          end
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
    end

    if (emit_c) begin
      scope_valid_d = 1'b1;
      scope_d       = scope_t'(win_d);
    end
  end

  assign sif.in_ready    = in_ready_c;
  assign sif.scope       = scope_q;
  assign sif.scope_valid = scope_valid_q;
  assign sif.frame_done  = frame_done_q;
  assign sif.frame_err   = frame_err_q;

`ifdef WIN_COORD_EN
  logic [COORD_W-1:0] win_x_q, win_x_d;
  logic [COORD_W-1:0] win_y_q, win_y_d;

  // Centre of the emitted window is one column left and one line up of the trigger pixel.
  always_comb begin
    win_x_d = win_x_q;
    win_y_d = win_y_q;
    if (emit_c) begin
      win_x_d = COORD_W'(col_q) - COORD_W'(1);
      win_y_d = COORD_W'(row_q) - COORD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_x_q <= '0;
      win_y_q <= '0;
    end else begin
      win_x_q <= win_x_d;
      win_y_q <= win_y_d;
    end
  end

  assign sif.win_x = win_x_q;
  assign sif.win_y = win_y_q;
`endif

endmodule

// File: tb/tb_scope_window_gen.sv
// Bench for scope_window_gen: directed frames plus randomized frames against a frame-level window model.
module tb_scope_window_gen;

  typedef struct packed {
    logic [71:0] s;
    logic [9:0]  x;
    logic [9:0]  y;
  } win_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  scope_window_gen_if ia ();
  scope_window_gen_if ib ();

  logic [7:0] drv_pix   = '0;
  logic       drv_sof   = 1'b0;
  logic       drv_valid = 1'b0;
  logic       srdy;
  bit         sel       = 1'b0;

  assign ia.in_pix      = drv_pix;
  assign ib.in_pix      = drv_pix;
  assign ia.in_sof      = drv_sof;
  assign ib.in_sof      = drv_sof;
  assign ia.in_valid    = drv_valid && !sel;
  assign ib.in_valid    = drv_valid && sel;
  assign ia.scope_ready = srdy;
  assign ib.scope_ready = srdy;

  scope_window_gen #(.IMG_W(4), .IMG_H(4)) dut_a (.clk(clk), .rst(rst), .sif(ia.slave));
  scope_window_gen #(.IMG_W(5), .IMG_H(3)) dut_b (.clk(clk), .rst(rst), .sif(ib.slave));

  logic        cur_sv, cur_inrdy, cur_fd, cur_fe;
  logic [71:0] cur_scope;
  logic [9:0]  cur_x, cur_y;

  always_comb begin
    cur_sv    = sel ? ib.scope_valid : ia.scope_valid;
    cur_inrdy = sel ? ib.in_ready    : ia.in_ready;
    cur_fd    = sel ? ib.frame_done  : ia.frame_done;
    cur_fe    = sel ? ib.frame_err   : ia.frame_err;
    cur_scope = sel ? ib.scope       : ia.scope;
`ifdef WIN_COORD_EN
    cur_x     = sel ? ib.win_x : ia.win_x;
    cur_y     = sel ? ib.win_y : ia.win_y;
`else
    cur_x     = '0;
    cur_y     = '0;
`endif
  end

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  win_t        got_q[$];
  win_t        exp_q[$];
  win_t        mon_w;
  int          n_done    = 0;
  int          n_err     = 0;
  int          hold_seen = 0;
  int unsigned done_cyc  = 0;
  int unsigned last_acc  = 0;
  logic        hold_p    = 1'b0;
  logic [71:0] hold_s    = '0;

  // Observer: window transfers, pulses and output-hold behaviour.
  always @(negedge clk) begin
    if (rst) begin
      hold_p = 1'b0;
    end else begin
      if (hold_p) begin
        check("hold_scope", cur_scope, hold_s);
        check("hold_valid", 72'(cur_sv), 72'd1);
      end
      if (cur_sv && !srdy) begin
        hold_seen++;
        check("hold_in_ready", 72'(cur_inrdy), 72'd0);
      end
      if (cur_sv && srdy) begin
        mon_w.s = cur_scope;
        mon_w.x = cur_x;
        mon_w.y = cur_y;
        got_q.push_back(mon_w);
      end
      if (cur_fd) begin
        n_done++;
        done_cyc = cyc;
      end
      if (cur_fe) n_err++;
      hold_p = cur_sv && !srdy;
      hold_s = cur_scope;
    end
  end

  // Convolver model: 0 always ready, 1 waits 9 cycles per window, 2 random, 3 never.
  int rmode    = 0;
  int wait_cnt = 0;
  always @(posedge clk) begin
    #1;
    case (rmode)
      1: begin
        if (cur_sv && wait_cnt < 9) begin
          srdy = 1'b0;
          wait_cnt++;
        end else begin
          srdy = 1'b1;
          wait_cnt = 0;
        end
      end
      2:       srdy = 1'($urandom_range(0, 1));
      3:       srdy = 1'b0;
      default: srdy = 1'b1;
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] p, input logic s);
    int n;
    n = 0;
    drv_pix   = p;
    drv_sof   = s;
    drv_valid = 1'b1;
    @(negedge clk);
    while (!cur_inrdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cur_inrdy) check("accept_timeout", 72'(cur_inrdy), 72'd1);
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
    drv_sof   = 1'b0;
    last_acc  = cyc;
  endtask

  task automatic send_frame(input logic [7:0] p[$], input int gapmax);
    foreach (p[i]) begin
      if (gapmax > 0) idle(int'($urandom_range(0, gapmax)));
      send(p[i], i == 0);
    end
  endtask

  // Reference: every interior 3x3 neighbourhood of the frame, in raster order of its centre.
  function automatic void model(input int w, input int h, input logic [7:0] p[$]);
    win_t e;
    for (int r = 2; r < h; r++) begin
      for (int c = 2; c < w; c++) begin
        e = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.s[(i*3+j)*8 +: 8] = p[(r-2+i)*w + (c-2+j)];
        e.x = 10'(c - 1);
        e.y = 10'(r - 1);
        exp_q.push_back(e);
      end
    end
  endfunction

  function automatic logic [71:0] pack9(input int v[9]);
    logic [71:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[k*8 +: 8] = 8'(v[k]);
    return r;
  endfunction

  task automatic new_test();
    got_q.delete();
    exp_q.delete();
    n_done    = 0;
    n_err     = 0;
    hold_seen = 0;
    done_cyc  = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (cur_sv && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (cur_sv) check("drain_timeout", 72'(cur_sv), 72'd0);
    idle(2);
  endtask

  task automatic end_frame(input string tag, input int exp_err);
    drain();
    check($sformatf("%s_count", tag), 72'(got_q.size()), 72'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_win%0d", tag, i), got_q[i].s, exp_q[i].s);
`ifdef WIN_COORD_EN
      check($sformatf("%s_x%0d", tag, i), 72'(got_q[i].x), 72'(exp_q[i].x));
      check($sformatf("%s_y%0d", tag, i), 72'(got_q[i].y), 72'(exp_q[i].y));
`endif
    end
    check($sformatf("%s_done_cnt", tag), 72'(n_done), 72'd1);
    check($sformatf("%s_done_lat", tag), 72'(done_cyc), 72'(last_acc));
    check($sformatf("%s_err_cnt", tag), 72'(n_err), 72'(exp_err));
  endtask

  task automatic check_ref(input string tag, input win_t r[$]);
    check($sformatf("%s_ref_count", tag), 72'(got_q.size()), 72'(r.size()));
    for (int i = 0; i < got_q.size() && i < r.size(); i++)
      check($sformatf("%s_ref%0d", tag, i), got_q[i].s, r[i].s);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_scope"},    cur_scope,        72'd0);
    check({tag, "_valid"},    72'(cur_sv),      72'd0);
    check({tag, "_done"},     72'(cur_fd),      72'd0);
    check({tag, "_err"},      72'(cur_fe),      72'd0);
    check({tag, "_in_ready"}, 72'(cur_inrdy),   72'd1);
  endtask

  initial begin
    logic [7:0] px[$];
    logic [7:0] f2[$];
    win_t       ref1[$];
    int         first_w[9];
    int         last_w[9];

    first_w = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    last_w  = '{5, 6, 7, 9, 10, 11, 13, 14, 15};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1;

    // 4x4 ramp, convolver always ready.
    new_test();
    px.delete();
    for (int i = 0; i < 16; i++) px.push_back(8'(i));
    model(4, 4, px);
    send_frame(px, 0);
    end_frame("ramp4", 0);
    check("ramp4_n4", 72'(got_q.size()), 72'd4);
    if (got_q.size() > 0) begin
      check("ramp4_first", got_q[0].s, pack9(first_w));
      check("ramp4_last", got_q[got_q.size()-1].s, pack9(last_w));
    end
    ref1 = got_q;

    // Same frame at convolver pace.
    rmode = 1;
    new_test();
    model(4, 4, px);
    send_frame(px, 0);
    end_frame("bp", 0);
    check_ref("bp", ref1);
    check("bp_stalled", 72'(hold_seen > 0), 72'd1);
    rmode = 0;

    // 5x3 line wrap.
    sel = 1'b1;
    new_test();
    px.delete();
    for (int i = 0; i < 15; i++) px.push_back(8'(i));
    model(5, 3, px);
    send_frame(px, 0);
    end_frame("wrap", 0);
    check("wrap_n3", 72'(got_q.size()), 72'd3);
    if (got_q.size() > 2) begin
      check("wrap_rc0", 72'(got_q[2].s[2*8 +: 8]), 72'd4);
      check("wrap_rc1", 72'(got_q[2].s[5*8 +: 8]), 72'd9);
      check("wrap_rc2", 72'(got_q[2].s[8*8 +: 8]), 72'd14);
    end
    sel = 1'b0;

    // Start-of-frame on pixel index 6 restarts the frame there.
    new_test();
    px.delete();
    for (int i = 0; i < 6; i++) px.push_back(8'(i));
    send_frame(px, 0);
    f2.delete();
    for (int i = 0; i < 16; i++) f2.push_back(8'(100 + 3 * i));
    model(4, 4, f2);
    send_frame(f2, 0);
    end_frame("sof", 1);

    // Reset mid-frame with a window left pending, then a clean frame.
    rmode = 3;
    new_test();
    px.delete();
    for (int i = 0; i < 11; i++) px.push_back(8'(i));
    send_frame(px, 0);
    @(negedge clk);
    check("rst_pending", 72'(cur_sv), 72'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrst");
    @(posedge clk);
    #1;
    rmode = 0;
    new_test();
    px.delete();
    for (int i = 0; i < 16; i++) px.push_back(8'(i));
    model(4, 4, px);
    send_frame(px, 0);
    end_frame("postrst", 0);
    check_ref("postrst", ref1);

    // Random pixels, random gaps, random convolver readiness.
    rmode = 2;
    for (int f = 0; f < 6; f++) begin
      int w;
      int h;
      sel = (f % 3 == 2);
      w   = sel ? 5 : 4;
      h   = sel ? 3 : 4;
      new_test();
      px.delete();
      for (int i = 0; i < w * h; i++) px.push_back(8'($urandom));
      model(w, h, px);
      send_frame(px, 2);
      end_frame($sformatf("rnd%0d", f), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
